// File: rtl/multi_cycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// multi_cycle_ctrl_if
//
// Bundles everything that passes between the multi-cycle controller and the
// rest of the CPU: the instruction-side and memory handshake inputs, the
// datapath control strobes and the status/observability outputs.
//
//   Opcode     4   opcode from the instruction register (valid from DECODE)
//   Zero       1   ALU zero flag
//   mem_ready  1   memory completes the current MemR/MemW access this cycle
//   PCWr       1   PC write enable
//   IRWr       1   instruction register write enable
//   IorD       1   memory address select (0 = PC, 1 = ALU result)
//   RegWr      1   register file write enable
//   RegDes     1   destination select (1 = rd, 0 = rt)
//   AluSrc     1   ALU B operand select (1 = immediate)
//   Mem2Reg    1   write-back data select (1 = memory data)
//   MemR/MemW  1   memory read / write strobes
//   Branch     1   branch evaluation cycle
//   Jump       1   jump target select
//   sti        1   store-immediate data select
//   state      3   current controller state
//   instr_done 1   one-cycle retire pulse
//   illegal    1   one-cycle illegal-opcode pulse
//   retired    16  retired-instruction count
//
// master: the datapath side (drives Opcode/Zero/mem_ready).
// slave : the controller (drives the strobes and status).
// ---------------------------------------------------------------------------
interface multi_cycle_ctrl_if;

    logic [3:0]  Opcode;
    logic        Zero;
    logic        mem_ready;

    logic        PCWr;
    logic        IRWr;
    logic        IorD;
    logic        RegWr;
    logic        RegDes;
    logic        AluSrc;
    logic        Mem2Reg;
    logic        MemR;
    logic        MemW;
    logic        Branch;
    logic        Jump;
    logic        sti;

    logic [2:0]  state;
    logic        instr_done;
    logic        illegal;
    logic [15:0] retired;

    modport master (
        output Opcode, Zero, mem_ready,
        input  PCWr, IRWr, IorD, RegWr, RegDes, AluSrc, Mem2Reg,
        input  MemR, MemW, Branch, Jump, sti,
        input  state, instr_done, illegal, retired
    );

    modport slave (
        input  Opcode, Zero, mem_ready,
        output PCWr, IRWr, IorD, RegWr, RegDes, AluSrc, Mem2Reg,
        output MemR, MemW, Branch, Jump, sti,
        output state, instr_done, illegal, retired
    );

endinterface

// File: rtl/multi_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// multi_cycle_ctrl
//
// Control unit for a small multi-cycle CPU. A five-state FSM
// (FETCH, DECODE, EXEC, MEM, WB) sequences each instruction and produces the
// datapath strobes. The opcode is captured in DECODE and every later state
// decodes from the captured copy, so the instruction register may change
// underneath the controller once DECODE has passed.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset; also forces every control strobe,
//          instr_done and illegal low combinationally while asserted
//   bus    multi_cycle_ctrl_if.slave (opcode/flags/handshake in, strobes and
//          status out)
//
// Opcode map: 0-4 R-type, 5 addi, 6 st, 7 ld, 8 beq, 9 jmp, 10 sti,
// 11-15 illegal.
//
// Latency with mem_ready held high: jmp 2, beq 3, R-type/addi/st/sti 4,
// ld 5 cycles; every low mem_ready cycle in FETCH or MEM adds one.
// ---------------------------------------------------------------------------
module multi_cycle_ctrl (
    input  logic               clk,
    input  logic               rst_n,
    multi_cycle_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [3:0] OP_ADDI = 4'd5;
    localparam logic [3:0] OP_ST   = 4'd6;
    localparam logic [3:0] OP_LD   = 4'd7;
    localparam logic [3:0] OP_BEQ  = 4'd8;
    localparam logic [3:0] OP_JMP  = 4'd9;
    localparam logic [3:0] OP_STI  = 4'd10;

    // All datapath strobes in one bundle so "everything off" is a single '0.
    typedef struct packed {
        logic pc_wr;
        logic ir_wr;
        logic i_or_d;
        logic reg_wr;
        logic reg_des;
        logic alu_src;
        logic mem2reg;
        logic mem_r;
        logic mem_w;
        logic branch;
        logic jump;
        logic sti;
    } ctrl_t;

    // ------------------------------------------------------------------
    // Opcode classification
    // ------------------------------------------------------------------
    function automatic logic is_rtype(input logic [3:0] op);
        return op <= 4'd4;
    endfunction

    function automatic logic is_illegal(input logic [3:0] op);
        return op >= 4'd11;
    endfunction

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LD) || (op == OP_ST) || (op == OP_STI);
    endfunction

    function automatic logic uses_imm(input logic [3:0] op);
        return (op == OP_ADDI) || is_mem_op(op);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t      state_q;
    state_t      state_d;
    logic [3:0]  op_q;
    logic [15:0] retired_q;

    logic        op_load;
    ctrl_t       ctrl;
    logic        done;
    logic        illegal;

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values of the others; blocking here would create ordering
    // dependent simulation and mismatch the synthesized netlist.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            op_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (op_load) begin
                op_q <= bus.Opcode;
            end
            // 16-bit add wraps 0xFFFF -> 0x0000 naturally.
            if (done) begin
                retired_q <= retired_q + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    // NOTE: every signal written below is given a default first; a path that
    // left one unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        op_load = 1'b0;
        ctrl    = '0;
        done    = 1'b0;
        illegal = 1'b0;

        case (state_q)
            S_FETCH: begin
                ctrl.mem_r  = 1'b1;
                ctrl.i_or_d = 1'b0;
                // The fetch only lands (IR loaded, PC advanced) in the cycle
                // memory actually delivers the word.
                if (bus.mem_ready) begin
                    ctrl.ir_wr = 1'b1;
                    ctrl.pc_wr = 1'b1;
                    state_d    = S_DECODE;
                end
            end

            S_DECODE: begin
                // DECODE is the only state that looks at the live Opcode.
                op_load = 1'b1;
                if (is_illegal(bus.Opcode)) begin
                    illegal = 1'b1;
                    state_d = S_FETCH;
                end else if (bus.Opcode == OP_JMP) begin
                    ctrl.jump  = 1'b1;
                    ctrl.pc_wr = 1'b1;
                    done       = 1'b1;
                    state_d    = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                ctrl.alu_src = uses_imm(op_q);
                if (op_q == OP_BEQ) begin
                    ctrl.branch = 1'b1;
                    ctrl.pc_wr  = bus.Zero;
                    done        = 1'b1;
                    state_d     = S_FETCH;
                end else if (is_mem_op(op_q)) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end

            S_MEM: begin
                // Strobes are Moore outputs of MEM/op_q, so they stay up for
                // as many cycles as the memory stalls.
                ctrl.i_or_d = 1'b1;
                ctrl.mem_r  = (op_q == OP_LD);
                ctrl.mem_w  = (op_q == OP_ST) || (op_q == OP_STI);
                ctrl.sti    = (op_q == OP_STI);
                if (bus.mem_ready) begin
                    if (op_q == OP_LD) begin
                        state_d = S_WB;
                    end else begin
                        done    = 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end

            S_WB: begin
                ctrl.reg_wr  = 1'b1;
                ctrl.reg_des = is_rtype(op_q);
                ctrl.mem2reg = (op_q == OP_LD);
                done         = 1'b1;
                state_d      = S_FETCH;
            end

            default: begin
                // Unused encodings 5-7: outputs stay at their zero defaults.
                state_d = S_FETCH;
            end
        endcase

        // Reset kills the strobes in the same cycle rst_n falls, so an
        // in-flight store is abandoned without a trailing MemW or retire.
        if (!rst_n) begin
            ctrl    = '0;
            done    = 1'b0;
            illegal = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign bus.PCWr       = ctrl.pc_wr;
    assign bus.IRWr       = ctrl.ir_wr;
    assign bus.IorD       = ctrl.i_or_d;
    assign bus.RegWr      = ctrl.reg_wr;
    assign bus.RegDes     = ctrl.reg_des;
    assign bus.AluSrc     = ctrl.alu_src;
    assign bus.Mem2Reg    = ctrl.mem2reg;
    assign bus.MemR       = ctrl.mem_r;
    assign bus.MemW       = ctrl.mem_w;
    assign bus.Branch     = ctrl.branch;
    assign bus.Jump       = ctrl.jump;
    assign bus.sti        = ctrl.sti;

    assign bus.state      = state_q;
    assign bus.instr_done = done;
    assign bus.illegal    = illegal;
    assign bus.retired    = retired_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multi_cycle_ctrl
//
// Self-checking bench for multi_cycle_ctrl. Each cycle's stimulus is driven
// together with the expected state, strobe vector and pulses, which are
// queued and then popped and compared on the falling edge. The expected
// retire count is tracked by the bench from the expected instr_done pulses.
// ---------------------------------------------------------------------------
module tb_multi_cycle_ctrl;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    multi_cycle_ctrl_if bus ();

    multi_cycle_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Strobe vector order: PCWr IRWr IorD RegWr RegDes AluSrc Mem2Reg
    //                      MemR MemW Branch Jump sti
    localparam logic [11:0] C_PCWR    = 12'h800;
    localparam logic [11:0] C_IRWR    = 12'h400;
    localparam logic [11:0] C_IORD    = 12'h200;
    localparam logic [11:0] C_REGWR   = 12'h100;
    localparam logic [11:0] C_REGDES  = 12'h080;
    localparam logic [11:0] C_ALUSRC  = 12'h040;
    localparam logic [11:0] C_MEM2REG = 12'h020;
    localparam logic [11:0] C_MEMR    = 12'h010;
    localparam logic [11:0] C_MEMW    = 12'h008;
    localparam logic [11:0] C_BRANCH  = 12'h004;
    localparam logic [11:0] C_JUMP    = 12'h002;
    localparam logic [11:0] C_STI     = 12'h001;
    localparam logic [11:0] C_NONE    = 12'h000;

    localparam logic [2:0] ST_F = 3'd0;
    localparam logic [2:0] ST_D = 3'd1;
    localparam logic [2:0] ST_E = 3'd2;
    localparam logic [2:0] ST_M = 3'd3;
    localparam logic [2:0] ST_W = 3'd4;

    // Opcode driven outside DECODE: illegal, so a controller that decodes the
    // live Opcode instead of the captured one goes visibly wrong.
    localparam logic [3:0] GARB = 4'hE;

    typedef struct {
        logic [2:0]  st;
        logic [11:0] ctrl;
        logic        done;
        logic        ill;
        string       tag;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] sb_retired = 16'd0;

    function automatic logic [11:0] ctrl_now();
        return {bus.PCWr, bus.IRWr, bus.IorD, bus.RegWr, bus.RegDes,
                bus.AluSrc, bus.Mem2Reg, bus.MemR, bus.MemW, bus.Branch,
                bus.Jump, bus.sti};
    endfunction

    // One clock cycle: drive inputs, queue expectation, compare at negedge.
    task automatic cyc(input logic rst, input logic [3:0] op, input logic z,
                       input logic mr, input logic [2:0] st,
                       input logic [11:0] c, input logic d, input logic il,
                       input string tag);
        exp_t e;
        rst_n         = rst;
        bus.Opcode    = op;
        bus.Zero      = z;
        bus.mem_ready = mr;
        sb_q.push_back('{st, c, d, il, tag});
        @(negedge clk);
        e = sb_q.pop_front();

        n_cmp++;
        if (bus.state !== e.st) begin
            n_bad++;
            $display("FAIL %s state: got %0d expected %0d", e.tag, bus.state, e.st);
        end
        n_cmp++;
        if (ctrl_now() !== e.ctrl) begin
            n_bad++;
            $display("FAIL %s ctrl: got %03h expected %03h", e.tag, ctrl_now(), e.ctrl);
        end
        n_cmp++;
        if ({bus.instr_done, bus.illegal} !== {e.done, e.ill}) begin
            n_bad++;
            $display("FAIL %s done/illegal: got %b%b expected %b%b",
                     e.tag, bus.instr_done, bus.illegal, e.done, e.ill);
        end
        n_cmp++;
        if (bus.retired !== sb_retired) begin
            n_bad++;
            $display("FAIL %s retired: got %04h expected %04h", e.tag, bus.retired, sb_retired);
        end
        n_cmp++;
        if ((bus.MemR && bus.MemW) || (bus.RegWr && bus.MemW)) begin
            n_bad++;
            $display("FAIL %s exclusive: got MemR=%b MemW=%b RegWr=%b expected no overlap",
                     e.tag, bus.MemR, bus.MemW, bus.RegWr);
        end

        if (!rst) sb_retired = 16'd0;
        else if (e.done) sb_retired = sb_retired + 16'd1;
        @(posedge clk);
        #1;
    endtask

    // Full instruction from FETCH, with f_wait / m_wait low mem_ready cycles
    // in FETCH and MEM. Expected strobes come straight from the opcode table.
    task automatic run_instr(input logic [3:0] op, input logic z,
                             input int f_wait, input int m_wait);
        logic [11:0] mc;
        for (int i = 0; i < f_wait; i++)
            cyc(1'b1, GARB, z, 1'b0, ST_F, C_MEMR, 1'b0, 1'b0, "fetch_wait");
        cyc(1'b1, GARB, z, 1'b1, ST_F, C_MEMR | C_IRWR | C_PCWR, 1'b0, 1'b0, "fetch");

        if (op >= 4'd11) begin
            cyc(1'b1, op, z, 1'b1, ST_D, C_NONE, 1'b0, 1'b1, "decode_illegal");
            return;
        end
        if (op == 4'd9) begin
            cyc(1'b1, op, z, 1'b1, ST_D, C_JUMP | C_PCWR, 1'b1, 1'b0, "decode_jmp");
            return;
        end
        cyc(1'b1, op, z, 1'b1, ST_D, C_NONE, 1'b0, 1'b0, "decode");

        if (op == 4'd8) begin
            cyc(1'b1, GARB, z, 1'b1, ST_E, C_BRANCH | (z ? C_PCWR : C_NONE),
                1'b1, 1'b0, "exec_beq");
            return;
        end
        if (op <= 4'd5) begin
            cyc(1'b1, GARB, z, 1'b1, ST_E, (op == 4'd5) ? C_ALUSRC : C_NONE,
                1'b0, 1'b0, "exec_alu");
            cyc(1'b1, GARB, z, 1'b1, ST_W,
                (op == 4'd5) ? C_REGWR : (C_REGWR | C_REGDES), 1'b1, 1'b0, "wb_alu");
            return;
        end

        // ld (7), st (6), sti (10)
        cyc(1'b1, GARB, z, 1'b1, ST_E, C_ALUSRC, 1'b0, 1'b0, "exec_mem");
        mc = C_IORD | ((op == 4'd7) ? C_MEMR : C_MEMW) | ((op == 4'd10) ? C_STI : C_NONE);
        for (int i = 0; i < m_wait; i++)
            cyc(1'b1, GARB, z, 1'b0, ST_M, mc, 1'b0, 1'b0, "mem_wait");
        cyc(1'b1, GARB, z, 1'b1, ST_M, mc, (op != 4'd7), 1'b0, "mem");
        if (op == 4'd7)
            cyc(1'b1, GARB, z, 1'b1, ST_W, C_REGWR | C_MEM2REG, 1'b1, 1'b0, "wb_ld");
    endtask

    task automatic test_reset();
        // Strobes forced low even though FETCH with mem_ready=1 would fire.
        cyc(1'b0, 4'd0, 1'b0, 1'b1, ST_F, C_NONE, 1'b0, 1'b0, "reset_0");
        cyc(1'b0, 4'd9, 1'b1, 1'b1, ST_F, C_NONE, 1'b0, 1'b0, "reset_1");
    endtask

    task automatic test_rtype();
        run_instr(4'd2, 1'b0, 0, 0);
        n_cmp++;
        if (bus.retired !== 16'd1) begin
            n_bad++;
            $display("FAIL rtype_retired: got %0d expected 1", bus.retired);
        end
    endtask

    task automatic test_alu_imm();
        run_instr(4'd5, 1'b0, 0, 0);
        run_instr(4'd0, 1'b1, 1, 0);
        run_instr(4'd4, 1'b0, 0, 0);
    endtask

    task automatic test_ld_wait();
        run_instr(4'd7, 1'b0, 0, 3);
        run_instr(4'd7, 1'b1, 0, 0);
    endtask

    task automatic test_store();
        run_instr(4'd6, 1'b0, 2, 1);
        run_instr(4'd10, 1'b0, 0, 0);
        run_instr(4'd10, 1'b1, 0, 2);
    endtask

    task automatic test_beq();
        run_instr(4'd8, 1'b0, 0, 0);
        run_instr(4'd8, 1'b1, 0, 0);
    endtask

    task automatic test_illegal();
        run_instr(4'd12, 1'b0, 0, 0);
        run_instr(4'd15, 1'b1, 0, 0);
        run_instr(4'd1, 1'b0, 0, 0);
    endtask

    task automatic test_jmp_wrap();
        // Preload the counter near wrap while idling in FETCH (no retire).
        force dut.retired_q = 16'hFFFD;
        sb_retired = 16'hFFFD;
        cyc(1'b1, GARB, 1'b0, 1'b0, ST_F, C_MEMR, 1'b0, 1'b0, "preload");
        release dut.retired_q;
        for (int i = 0; i < 6; i++)
            run_instr(4'd9, 1'b0, 0, 0);
        n_cmp++;
        if (bus.retired !== 16'h0003) begin
            n_bad++;
            $display("FAIL jmp_wrap: got %04h expected 0003", bus.retired);
        end
    endtask

    task automatic test_reset_mid_mem();
        cyc(1'b1, GARB, 1'b0, 1'b1, ST_F, C_MEMR | C_IRWR | C_PCWR, 1'b0, 1'b0, "sti_fetch");
        cyc(1'b1, 4'd10, 1'b0, 1'b1, ST_D, C_NONE, 1'b0, 1'b0, "sti_decode");
        cyc(1'b1, GARB, 1'b0, 1'b1, ST_E, C_ALUSRC, 1'b0, 1'b0, "sti_exec");
        cyc(1'b1, GARB, 1'b0, 1'b0, ST_M, C_IORD | C_MEMW | C_STI, 1'b0, 1'b0, "sti_mem_stall");
        // rst_n falls mid-MEM: strobes drop at once, state still MEM.
        cyc(1'b0, GARB, 1'b0, 1'b1, ST_M, C_NONE, 1'b0, 1'b0, "sti_rst_low");
        cyc(1'b0, GARB, 1'b0, 1'b1, ST_F, C_NONE, 1'b0, 1'b0, "sti_after_rst");
        // First edge after release runs FETCH normally.
        run_instr(4'd3, 1'b0, 0, 0);
    endtask

    task automatic test_back_to_back();
        logic [3:0] ops [13] = '{4'd0, 4'd1, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8,
                                  4'd9, 4'd10, 4'd11, 4'd13, 4'd8, 4'd7};
        for (int i = 0; i < 13; i++)
            run_instr(ops[i], 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.Opcode    = 4'd0;
        bus.Zero      = 1'b0;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;

        test_reset();
        test_rtype();
        test_alu_imm();
        test_ld_wait();
        test_store();
        test_beq();
        test_illegal();
        test_jmp_wrap();
        test_reset_mid_mem();
        test_back_to_back();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
